// File: rtl/regfile_pkg.sv
// regfile_pkg: register file widths and types shared by the register file, its write arbiter and the core writeback stages
package regfile_pkg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_priority_select.sv
// rr_priority_select: first asserted request at or after ptr, searching upward with wrap-around
module rr_priority_select #(
    parameter int CORES = 4,
    localparam int IDW = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic [CORES-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             valid,
    output logic [IDW-1:0]   idx
);
    localparam logic [IDW:0] L_CORES = (IDW+1)'(CORES);
    logic [CORES-1:0] w_rot;
    logic [IDW-1:0]   w_off;
    logic [IDW:0]     w_sum;
    assign w_rot = CORES'({req, req} >> ptr);
    always_comb begin
        w_off = '0;
        for (int i = CORES - 1; i >= 0; i--) w_off = w_rot[i] ? i[IDW-1:0] : w_off;
    end
    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign valid = |req;
    assign idx   = IDW'(w_sum >= L_CORES ? w_sum - L_CORES : w_sum);
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register file write port with a registered output stage and ack mask
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int CORES      = 4,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    localparam int IDW = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CORES-1:0]            req,
    input  logic [CORES*ADDR_WIDTH-1:0] req_addr,
    input  logic [CORES*DATA_WIDTH-1:0] req_data,
    output logic [CORES-1:0]            ack,
    output logic                        write_enable,
    output logic [ADDR_WIDTH-1:0]       write_address,
    output logic [DATA_WIDTH-1:0]       write_data,
    output logic [IDW-1:0]              grant_id
);
    logic [IDW-1:0]        r_ptr, r_gid, w_gid, w_nxt;
    logic [CORES-1:0]      r_ack, w_req;
    logic                  r_we, w_valid;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_data, w_data;
    // a core acked this cycle has not yet seen its ack, so its request is stale
    assign w_req = req & ~r_ack;
    rr_priority_select #(.CORES(CORES)) u_sel (
        .req   (w_req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_gid)
    );
    assign w_addr = req_addr[w_gid*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data = req_data[w_gid*DATA_WIDTH +: DATA_WIDTH];
    assign w_nxt  = (w_gid == IDW'(CORES - 1)) ? '0 : w_gid + 1'b1;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= '0;
            r_ack  <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_gid  <= '0;
        end else begin
            r_ack <= w_valid ? CORES'(1) << w_gid : '0;
            r_we  <= w_valid && (w_addr != ADDR_WIDTH'(REG_ZERO));
            if (w_valid) begin
                r_ptr  <= w_nxt;
                r_addr <= w_addr;
                r_data <= w_data;
                r_gid  <= w_gid;
            end
        end
    end
    assign ack           = r_ack;
    assign write_enable  = r_we;
    assign write_address = r_addr;
    assign write_data    = r_data;
    assign grant_id      = r_gid;
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the multi-core `registerfile` among `CORES` requesting cores. Each core raises a write request carrying an address and data. The arbiter selects one core per cycle in round-robin order, drives the register file's `write_enable` / `write_address` / `write_data` from a registered stage, and returns a one-cycle `ack` to the winner. It sits between the per-core writeback stages and the register file write port.

## Interface
Parameters:
- `CORES`, 4, number of requesting cores (≥1)
- `ADDR_WIDTH`, 5, register address width
- `DATA_WIDTH`, 32, register data width

Ports:
- `clk`  in  1  clock, positive-edge triggered
- `reset`  in  1  synchronous, active-high reset
- `req`  in  `CORES`  per-core write request, level
- `req_addr`  in  `CORES*ADDR_WIDTH`  flattened; core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_data`  in  `CORES*DATA_WIDTH`  flattened; core i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `ack`  out  `CORES`  one-hot, one-cycle grant acknowledge
- `write_enable`  out  1  to register file
- `write_address`  out  `ADDR_WIDTH`  to register file
- `write_data`  out  `DATA_WIDTH`  to register file
- `grant_id`  out  `max(1,$clog2(CORES))`  index of the core granted in the current `ack` cycle

## Operation
- Requester handshake:
  - Core i asserts `req[i]` and holds `req_addr` / `req_data` stable until it samples `ack[i]=1` at a posedge.
  - After that edge it drops `req[i]` or presents a new write.
- Arbitration:
  - Each cycle the arbiter considers `req & ~ack`; a core being acked this cycle is masked out.
  - It picks the first asserted index at or after `ptr`, searching upward and wrapping at `CORES-1` → 0.
- Pointer update:
  - On a grant to core g, `ptr` ← (g+1) mod `CORES`.
  - With no grant, `ptr` holds.
- Output stage (registered):
  - On the edge after selection, the stage loads `ack[g]=1`, `grant_id=g`, `write_address=req_addr[g]`, `write_data=req_data[g]`, and `write_enable=1`.
- Register zero: a request with address 0 is granted and acked normally, but `write_enable` stays 0 for that cycle. `write_address` and `write_data` are still loaded.
- No request: `ack=0` and `write_enable=0`. `write_address`, `write_data` and `grant_id` hold their previous values.
- Fairness: a continuously asserted `req[i]` is acked within `CORES` grants.
- Single continuous requester: acked every other cycle, because of the ack mask. Two or more requesters achieve one write per cycle.
- `CORES=1`: `ptr` is constant 0; the block degenerates to a registered pass-through with the ack mask.

## Timing
- `req` sampled at posedge k → `ack` and write outputs valid during cycle k+1 → register file writes at posedge k+1. The latency is exactly 1 cycle when uncontended.
- `ack` and `write_enable` are never high for more than one consecutive cycle per core.
- Reset values (while `reset=1` at a posedge): `ack=0`, `write_enable=0`, `write_address=0`, `write_data=0`, `grant_id=0`, `ptr=0`.
- Reset mid-operation:
  - A grant loaded on the reset edge is discarded; no write occurs and no ack is issued.
  - Requesters keep `req` high and are re-arbitrated from `ptr=0` after reset deasserts.
- Simultaneous requests: resolved purely by `ptr`; address collisions between cores are not detected. The later grant's data wins.
- Requests that change without an ack are a protocol violation; the behaviour is undefined.

## Structure
- Shared package `regfile_pkg` holds:
  - `REG_ADDR_WIDTH=5`, `REG_DATA_WIDTH=32`, `REG_ZERO=5'd0`
  - typedefs `reg_addr_t` and `reg_data_t`
  - These are used by this block, `registerfile`, and the core writeback stages.
- One combinational sub-module, `rr_priority_select`:
  - Inputs: `CORES`-bit request vector and `ptr`.
  - Outputs: `valid` and a granted index.
  - Implemented as a double-width rotate plus a priority encoder.
- The top level holds `ptr`, the ack mask, the output registers and the zero-address suppression.

## Test plan
- **Reset:** assert `reset` 2 cycles with all `req=1` → `ack=0`, `write_enable=0`, all outputs 0. Release → first ack goes to core 0.
- **Single write:** core 2 requests addr 5'b01111 with data 32'h15 → the next cycle has `ack=4'b0100`, `write_enable=1`, addr 01111, data 32'h15. A subsequent `registerfile` read of 01111 returns 32'h15.
- **Round-robin:** all 4 cores request continuously → acks in order 0,1,2,3,0,… with one write per cycle and no core skipped.
- **Register zero:** core 1 requests addr 0 with data 32'hDEAD → `ack[1]=1` and `write_enable=0`. A read of register 0 returns 0.
- **Wrap and mask:**
  - After a grant to core 3, cores 0 and 3 request → core 0 is acked first, then core 3.
  - A lone core 3 holding `req` → acked every other cycle.
- **Mid-operation reset:** reset asserted on the cycle after core 1 is selected → no `write_enable` pulse occurs. After release with core 1 still requesting, core 1 is acked one cycle later.
